ysyx_23060042_ifetch: RTL and testbench

// - Multi-cycle instruction fetch controller placed in front of the decoder; replaces the single-cycle fetch path.
// - Owns the architectural PC.
// - Issues one word-aligned fetch request per instruction over a valid/ready memory request/response pair.
// - Presents {pc, inst} to the decode stage over a valid/ready handshake.
// - Accepts PC redirects from the execute stage (jumps, branches).

---
 rtl/ysyx_23060042_ifetch.sv | 136 +++++++++++++
 tb/tb_ysyx_23060042_ifetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060042_ifetch.sv
// Multi-cycle instruction fetch controller: owns the PC, issues one request at a time, hands {pc, inst} to decode.
// Optional macro IFETCH_FAULT_EN adds out_fault and suppresses misaligned fetches.
module ysyx_23060042_ifetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
`ifdef IFETCH_FAULT_EN
  ,
  output logic              out_fault
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              misaligned;

`ifdef IFETCH_FAULT_EN
  logic fault_q, fault_d;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign out_fault  = fault_q;
`else
  logic unused_rsp_err;
  assign misaligned     = 1'b0;
  assign unused_rsp_err = rsp_err;
`endif

  assign req_valid = (state_q == S_REQ) && !misaligned;
  assign req_addr  = pc_q;
  assign rsp_ready = (state_q == S_WAIT);
  assign out_valid = (state_q == S_HOLD);
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
`ifdef IFETCH_FAULT_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misaligned && !redirect_valid) begin
          state_d    = S_HOLD;
          out_inst_d = '0;
          out_pc_d   = pc_q;
`ifdef IFETCH_FAULT_EN
          fault_d    = 1'b1;
`endif
        end else if (req_valid && req_ready) begin
          // A redirect racing the request handshake leaves a stale response in flight.
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_inst_d = rsp_data;
            out_pc_d   = pc_q;
`ifdef IFETCH_FAULT_EN
            fault_d    = rsp_err;
`endif
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect target always overrides the sequential increment.
    if (redirect_valid) pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      out_inst_q <= '0;
      out_pc_q   <= RESET_PC;
`ifdef IFETCH_FAULT_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
`ifdef IFETCH_FAULT_EN
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_ifetch.sv
// Directed bench for ysyx_23060042_ifetch: memory responder model plus request/output scoreboards.
module tb_ysyx_23060042_ifetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = '0;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef IFETCH_FAULT_EN
  logic        out_fault;
`endif

  int total = 0;
  int bad = 0;
  int out_hs = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_out[$];

  int          rsp_delay = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  ysyx_23060042_ifetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef IFETCH_FAULT_EN
    , .out_fault(out_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_000C) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    int n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 32'(req_valid), 32'd1);
    check(tag, req_addr, a);
  endtask

  task automatic wait_out(input logic [31:0] pc, input logic [31:0] inst, input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst);
  endtask

  // Memory responder: rsp_delay=0 answers in the cycle right after the request handshake.
  always @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      pend      <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (pend) begin
        if (pend_cnt == 1) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mem_word(pend_addr);
          pend      <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (req_valid && req_ready) begin
        if (rsp_delay == 0) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mem_word(req_addr);
        end else begin
          pend      <= 1'b1;
          pend_cnt  <= rsp_delay;
          pend_addr <= req_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        total++;
        assert (exp_req.size() != 0) else begin
          bad++;
          $error("FAIL req_unexpected got=%h exp=none", req_addr);
        end
        if (exp_req.size() != 0) check("req_addr", req_addr, exp_req.pop_front());
      end
      if (out_valid) begin
        total++;
        assert (out_inst !== 32'hDEAD_BEEF) else begin
          bad++;
          $error("FAIL stale_inst got=%h exp=not_deadbeef", out_inst);
        end
      end
      if (out_valid && out_ready) begin
        logic [63:0] e;
        out_hs++;
        total++;
        assert (exp_out.size() != 0) else begin
          bad++;
          $error("FAIL out_unexpected got=%h exp=none", out_pc);
        end
        if (exp_out.size() != 0) begin
          e = exp_out.pop_front();
          check("out_pc", out_pc, e[63:32]);
          check("out_inst", out_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    int hs;
    logic [31:0] a;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; out_ready = 1'b1; rsp_err = 1'b0;
    step(); step();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'h8000_0000);
`ifdef IFETCH_FAULT_EN
    check("rst_out_fault", 32'(out_fault), 32'd0);
`endif

    // Back-to-back fetch, memory always ready.
    for (int i = 0; i < 3; i++) begin
      a = 32'h8000_0000 + 32'(4 * i);
      exp_req.push_back(a);
      exp_out.push_back({a, mem_word(a)});
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("seq_out_valid", 32'(out_valid), 32'((k % 3) == 0));
      if (k % 3 == 1) check("seq_req_addr", req_addr, 32'h8000_0000 + 32'(4 * ((k - 1) / 3)));
    end

    // Decode stalls for 5 cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, 32'h8000_0008);
      check("hold_inst", out_inst, mem_word(32'h8000_0008));
      check("hold_no_req", 32'(req_valid), 32'd0);
    end
    exp_req.push_back(32'h8000_000C);
    out_ready = 1'b1;
    step();
    check("after_hold_req_addr", req_addr, 32'h8000_000C);

    // Redirect while waiting on a slow response.
    rsp_delay = 3;
    step();
    check("wait_rsp_ready", 32'(rsp_ready), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0; rsp_delay = 0;
    exp_req.push_back(32'h8000_0100);
    exp_out.push_back({32'h8000_0100, mem_word(32'h8000_0100)});
    wait_req(32'h8000_0100, "redir_wait_req");

    // Redirect in HOLD together with an output handshake.
    wait_out(32'h8000_0100, mem_word(32'h8000_0100), "redir_hold_pre");
    hs = out_hs;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    step();
    redirect_valid = 1'b0;
    check("redir_hold_hs", 32'(out_hs), 32'(hs + 1));
    check("redir_hold_req_addr", req_addr, 32'h8000_0040);
    check("redir_hold_out_valid", 32'(out_valid), 32'd0);

    // Reset pulse while a response is pending.
    exp_req.push_back(32'h8000_0040);
    rsp_delay = 2;
    step();
    rsp_delay = 0;
    check("rstw_rsp_ready", 32'(rsp_ready), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_req_valid", 32'(req_valid), 32'd0);
    check("rstw_rsp_ready_low", 32'(rsp_ready), 32'd0);
    check("rstw_out_valid", 32'(out_valid), 32'd0);
    check("rstw_out_pc", out_pc, 32'h8000_0000);
    check("rstw_out_inst", out_inst, 32'd0);
    exp_req.push_back(32'h8000_0000);
    exp_out.push_back({32'h8000_0000, mem_word(32'h8000_0000)});
    rsp_err = 1'b1;
    wait_req(32'h8000_0000, "post_rst_req");
    wait_out(32'h8000_0000, mem_word(32'h8000_0000), "post_rst_out");
    rsp_err = 1'b0;

    // Redirect in REQ without a handshake, then PC wrap-around.
    req_ready = 1'b0;
    step();
    check("req_stall_addr", req_addr, 32'h8000_0004);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("req_redir_valid", 32'(req_valid), 32'd1);
    check("req_redir_addr", req_addr, 32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_out.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    req_ready = 1'b1;
    wait_out(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), "wrap_out");
    req_ready = 1'b0;
    step();
    check("wrap_req_valid", 32'(req_valid), 32'd1);
    check("wrap_req_addr", req_addr, 32'd0);

`ifdef IFETCH_FAULT_EN
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    step();
    redirect_valid = 1'b0;
    check("mis_no_req", 32'(req_valid), 32'd0);
    step();
    check("mis_out_valid", 32'(out_valid), 32'd1);
    check("mis_out_fault", 32'(out_fault), 32'd1);
    check("mis_out_inst", out_inst, 32'd0);
    check("mis_out_pc", out_pc, 32'h8000_0002);
`endif

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
